// File: rtl/tx_pll_lock_sequencer.sv
// rtl/tx_pll_lock_sequencer.sv - transmit PLL lock qualification and lane reset release sequencer
module tx_pll_lock_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int PMA_RST_CYCLES     = 64,
    parameter int PCS_RST_CYCLES     = 32,
    parameter int TIMEOUT_CYCLES     = 65536
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       PLL_LOCK,
    input  logic       CLR_STATUS,
    output logic       LANE_PMA_ARST_N,
    output logic       LANE_PCS_ARST_N,
    output logic       READY,
    output logic       LOCK_LOST,
    output logic       LOCK_TIMEOUT,
    output logic [7:0] LOSS_COUNT,
    output logic [1:0] STATE
);

    localparam int STABLE_W  = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int PMA_W     = $clog2(PMA_RST_CYCLES + 1);
    localparam int PCS_W     = $clog2(PCS_RST_CYCLES + 1);
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [STABLE_W-1:0]  STABLE_MAX   = STABLE_W'(LOCK_STABLE_CYCLES);
    localparam logic [PMA_W-1:0]     PMA_LAST     = PMA_W'(PMA_RST_CYCLES - 1);
    localparam logic [PCS_W-1:0]     PCS_LAST     = PCS_W'(PCS_RST_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX  = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_PMA_RST   = 2'd1,
        ST_PCS_RST   = 2'd2,
        ST_READY     = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic [STABLE_W-1:0]    stable_cnt;
    logic [PMA_W-1:0]       pma_cnt;
    logic [PCS_W-1:0]       pcs_cnt;
    logic [TIMEOUT_W-1:0]   timeout_cnt;
    logic                   loss_evt;
    logic                   timeout_evt;
    logic                   stay_wait;

    assign lock_s    = sync_q[SYNC_STAGES-1];
    assign stay_wait = (state_q == ST_WAIT_LOCK) && (state_d == ST_WAIT_LOCK);
    assign STATE     = state_q;

    // Synchronizer chain: the only reader of the asynchronous PLL lock
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], PLL_LOCK};
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= ST_WAIT_LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus loss and timeout event decode
    always_comb begin
        state_d     = state_q;
        loss_evt    = 1'b0;
        timeout_evt = 1'b0;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s && (stable_cnt == STABLE_MAX)) begin
                    state_d = ST_PMA_RST;
                end
                timeout_evt = (timeout_cnt == TIMEOUT_LAST);
            end
            ST_PMA_RST: begin
                if (!lock_s) begin
                    loss_evt = 1'b1;
                    state_d  = ST_WAIT_LOCK;
                end else if (pma_cnt == PMA_LAST) begin
                    state_d = ST_PCS_RST;
                end
            end
            ST_PCS_RST: begin
                if (!lock_s) begin
                    loss_evt = 1'b1;
                    state_d  = ST_WAIT_LOCK;
                end else if (pcs_cnt == PCS_LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (!lock_s) begin
                    loss_evt = 1'b1;
                    state_d  = ST_WAIT_LOCK;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase
    end

    // Stable-lock and timeout counters live only while WAIT_LOCK persists; both saturate
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            stable_cnt  <= '0;
            timeout_cnt <= '0;
        end else if (stay_wait) begin
            if (!lock_s) begin
                stable_cnt <= '0;
            end else if (stable_cnt != STABLE_MAX) begin
                stable_cnt <= stable_cnt + STABLE_W'(1);
            end
            if (timeout_cnt != TIMEOUT_MAX) begin
                timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
            end
        end else begin
            stable_cnt  <= '0;
            timeout_cnt <= '0;
        end
    end

    // Dwell counters for the two lane reset phases, cleared on every phase entry
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            pma_cnt <= '0;
            pcs_cnt <= '0;
        end else begin
            if ((state_q == ST_PMA_RST) && (state_d == ST_PMA_RST)) begin
                pma_cnt <= pma_cnt + PMA_W'(1);
            end else begin
                pma_cnt <= '0;
            end
            if ((state_q == ST_PCS_RST) && (state_d == ST_PCS_RST)) begin
                pcs_cnt <= pcs_cnt + PCS_W'(1);
            end else begin
                pcs_cnt <= '0;
            end
        end
    end

    // Registered lane controls decoded from the next state so they move with STATE
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            LANE_PMA_ARST_N <= 1'b0;
            LANE_PCS_ARST_N <= 1'b0;
            READY           <= 1'b0;
            LOCK_LOST       <= 1'b0;
        end else begin
            LANE_PMA_ARST_N <= (state_d == ST_PCS_RST) || (state_d == ST_READY);
            LANE_PCS_ARST_N <= (state_d == ST_READY);
            READY           <= (state_d == ST_READY);
            LOCK_LOST       <= loss_evt;
        end
    end

    // Sticky status; a fresh event beats a simultaneous clear
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            LOCK_TIMEOUT <= 1'b0;
            LOSS_COUNT   <= 8'd0;
        end else begin
            if (timeout_evt) begin
                LOCK_TIMEOUT <= 1'b1;
            end else if (CLR_STATUS) begin
                LOCK_TIMEOUT <= 1'b0;
            end
            if (loss_evt) begin
                if (CLR_STATUS) begin
                    LOSS_COUNT <= 8'd1;
                end else if (LOSS_COUNT != 8'hFF) begin
                    LOSS_COUNT <= LOSS_COUNT + 8'd1;
                end
            end else if (CLR_STATUS) begin
                LOSS_COUNT <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_tx_pll_lock_sequencer.sv
// tb/tb_tx_pll_lock_sequencer.sv - directed self-checking bench for tx_pll_lock_sequencer
module tb_tx_pll_lock_sequencer;

    logic       CLK;
    logic       RESETN;
    logic       PLL_LOCK;
    logic       CLR_STATUS;
    logic       LANE_PMA_ARST_N;
    logic       LANE_PCS_ARST_N;
    logic       READY;
    logic       LOCK_LOST;
    logic       LOCK_TIMEOUT;
    logic [7:0] LOSS_COUNT;
    logic [1:0] STATE;

    int checks = 0;
    int errors = 0;

    tx_pll_lock_sequencer #(
        .SYNC_STAGES       (2),
        .LOCK_STABLE_CYCLES(8),
        .PMA_RST_CYCLES    (4),
        .PCS_RST_CYCLES    (4),
        .TIMEOUT_CYCLES    (32)
    ) dut (
        .CLK            (CLK),
        .RESETN         (RESETN),
        .PLL_LOCK       (PLL_LOCK),
        .CLR_STATUS     (CLR_STATUS),
        .LANE_PMA_ARST_N(LANE_PMA_ARST_N),
        .LANE_PCS_ARST_N(LANE_PCS_ARST_N),
        .READY          (READY),
        .LOCK_LOST      (LOCK_LOST),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT),
        .LOSS_COUNT     (LOSS_COUNT),
        .STATE          (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESETN     = 1'b0;
        PLL_LOCK   = 1'b0;
        CLR_STATUS = 1'b0;
        tick();
        tick();
        RESETN = 1'b1;
    endtask

    task automatic test_reset();
        RESETN     = 1'b0;
        PLL_LOCK   = 1'b1;
        CLR_STATUS = 1'b1;
        tick();
        PLL_LOCK = 1'b0;
        tick();
        PLL_LOCK = 1'b1;
        tick();
        CLR_STATUS = 1'b0;
        checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", STATE); end
        checks++; if (LANE_PMA_ARST_N !== 1'b0) begin errors++; $display("FAIL reset_pma got %0b expected 0", LANE_PMA_ARST_N); end
        checks++; if (LANE_PCS_ARST_N !== 1'b0) begin errors++; $display("FAIL reset_pcs got %0b expected 0", LANE_PCS_ARST_N); end
        checks++; if (READY !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b expected 0", READY); end
        checks++; if (LOCK_LOST !== 1'b0) begin errors++; $display("FAIL reset_lost got %0b expected 0", LOCK_LOST); end
        checks++; if (LOCK_TIMEOUT !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0b expected 0", LOCK_TIMEOUT); end
        checks++; if (LOSS_COUNT !== 8'd0) begin errors++; $display("FAIL reset_loss_count got %0d expected 0", LOSS_COUNT); end
    endtask

    task automatic test_lock_sequence();
        int pma_entry = -1;
        int pcs_entry = -1;
        int pma_rise  = -1;
        int pcs_rise  = -1;
        int rdy_rise  = -1;
        do_reset();
        PLL_LOCK = 1'b1;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (STATE == 2'd1 && pma_entry < 0) pma_entry = e;
            if (STATE == 2'd2 && pcs_entry < 0) pcs_entry = e;
            if (LANE_PMA_ARST_N === 1'b1 && pma_rise < 0) pma_rise = e;
            if (LANE_PCS_ARST_N === 1'b1 && pcs_rise < 0) pcs_rise = e;
            if (READY === 1'b1 && rdy_rise < 0) rdy_rise = e;
        end
        checks++; if (pma_entry !== 10) begin errors++; $display("FAIL seq_pma_entry got %0d expected 10", pma_entry); end
        checks++; if (pcs_entry !== 14) begin errors++; $display("FAIL seq_pcs_entry got %0d expected 14", pcs_entry); end
        checks++; if (pma_rise !== 14) begin errors++; $display("FAIL seq_pma_rise got %0d expected 14", pma_rise); end
        checks++; if (pcs_rise !== 18) begin errors++; $display("FAIL seq_pcs_rise got %0d expected 18", pcs_rise); end
        checks++; if (rdy_rise !== 18) begin errors++; $display("FAIL seq_ready_rise got %0d expected 18", rdy_rise); end
        checks++; if (STATE !== 2'd3) begin errors++; $display("FAIL seq_final_state got %0d expected 3", STATE); end
        checks++; if (LOCK_TIMEOUT !== 1'b0) begin errors++; $display("FAIL seq_no_timeout got %0b expected 0", LOCK_TIMEOUT); end
    endtask

    task automatic test_glitch();
        int pma_entry = -1;
        int rdy_rise  = -1;
        do_reset();
        for (int e = 0; e < 40; e++) begin
            PLL_LOCK = (e == 6) ? 1'b0 : 1'b1;
            tick();
            if (STATE == 2'd1 && pma_entry < 0) pma_entry = e;
            if (READY === 1'b1 && rdy_rise < 0) rdy_rise = e;
        end
        checks++; if (pma_entry !== 17) begin errors++; $display("FAIL glitch_pma_entry got %0d expected 17", pma_entry); end
        checks++; if (rdy_rise !== 25) begin errors++; $display("FAIL glitch_ready_rise got %0d expected 25", rdy_rise); end
        checks++; if (LOSS_COUNT !== 8'd0) begin errors++; $display("FAIL glitch_loss_count got %0d expected 0", LOSS_COUNT); end
    endtask

    task automatic test_loss_in_ready();
        int first_lost = -1;
        int pulses     = 0;
        int rdy_rise   = -1;
        PLL_LOCK = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (LOCK_LOST === 1'b1) begin
                pulses++;
                if (first_lost < 0) first_lost = e;
            end
            if (e == 1) begin
                checks++; if (READY !== 1'b1) begin errors++; $display("FAIL loss_ready_held got %0b expected 1", READY); end
            end
            if (e == 2) begin
                checks++; if (READY !== 1'b0) begin errors++; $display("FAIL loss_ready got %0b expected 0", READY); end
                checks++; if (LANE_PMA_ARST_N !== 1'b0) begin errors++; $display("FAIL loss_pma got %0b expected 0", LANE_PMA_ARST_N); end
                checks++; if (LANE_PCS_ARST_N !== 1'b0) begin errors++; $display("FAIL loss_pcs got %0b expected 0", LANE_PCS_ARST_N); end
                checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL loss_state got %0d expected 0", STATE); end
                checks++; if (LOSS_COUNT !== 8'd1) begin errors++; $display("FAIL loss_count got %0d expected 1", LOSS_COUNT); end
            end
        end
        checks++; if (first_lost !== 2) begin errors++; $display("FAIL loss_pulse_cycle got %0d expected 2", first_lost); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL loss_pulse_count got %0d expected 1", pulses); end
        PLL_LOCK = 1'b1;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (READY === 1'b1 && rdy_rise < 0) rdy_rise = e;
        end
        checks++; if (rdy_rise !== 18) begin errors++; $display("FAIL relock_ready_rise got %0d expected 18", rdy_rise); end
        checks++; if (LOSS_COUNT !== 8'd1) begin errors++; $display("FAIL relock_loss_count got %0d expected 1", LOSS_COUNT); end
    endtask

    task automatic test_timeout();
        do_reset();
        PLL_LOCK = 1'b0;
        repeat (31) tick();
        checks++; if (LOCK_TIMEOUT !== 1'b0) begin errors++; $display("FAIL timeout_early got %0b expected 0", LOCK_TIMEOUT); end
        CLR_STATUS = 1'b1;
        tick();
        CLR_STATUS = 1'b0;
        checks++; if (LOCK_TIMEOUT !== 1'b1) begin errors++; $display("FAIL timeout_set_with_clr got %0b expected 1", LOCK_TIMEOUT); end
        checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL timeout_still_waiting got %0d expected 0", STATE); end
        repeat (5) tick();
        checks++; if (LOCK_TIMEOUT !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %0b expected 1", LOCK_TIMEOUT); end
        PLL_LOCK = 1'b1;
        repeat (25) tick();
        checks++; if (READY !== 1'b1) begin errors++; $display("FAIL timeout_then_ready got %0b expected 1", READY); end
        checks++; if (LOCK_TIMEOUT !== 1'b1) begin errors++; $display("FAIL timeout_kept_in_ready got %0b expected 1", LOCK_TIMEOUT); end
        CLR_STATUS = 1'b1;
        tick();
        CLR_STATUS = 1'b0;
        checks++; if (LOCK_TIMEOUT !== 1'b0) begin errors++; $display("FAIL timeout_cleared got %0b expected 0", LOCK_TIMEOUT); end
        checks++; if (READY !== 1'b1) begin errors++; $display("FAIL clr_keeps_ready got %0b expected 1", READY); end
    endtask

    task automatic test_loss_saturation();
        bit ok;
        do_reset();
        for (int n = 1; n <= 260; n++) begin
            PLL_LOCK = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 30; k++) begin
                tick();
                if (STATE == 2'd1) begin ok = 1'b1; break; end
            end
            checks++;
            if (!ok) begin errors++; $display("FAIL sat_wait_pma got state %0d expected 1 at event %0d", STATE, n); break; end
            PLL_LOCK = 1'b0;
            ok = 1'b0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (STATE == 2'd0) begin ok = 1'b1; break; end
            end
            checks++;
            if (!ok) begin errors++; $display("FAIL sat_wait_loss got state %0d expected 0 at event %0d", STATE, n); break; end
            if (n == 100) begin
                checks++; if (LOSS_COUNT !== 8'd100) begin errors++; $display("FAIL sat_count_100 got %0d expected 100", LOSS_COUNT); end
            end
            if (n == 255) begin
                checks++; if (LOSS_COUNT !== 8'd255) begin errors++; $display("FAIL sat_count_255 got %0d expected 255", LOSS_COUNT); end
            end
        end
        checks++; if (LOSS_COUNT !== 8'd255) begin errors++; $display("FAIL sat_count_260 got %0d expected 255", LOSS_COUNT); end
        PLL_LOCK = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (STATE == 2'd1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL coincide_wait_pma got state %0d expected 1", STATE); end
        PLL_LOCK = 1'b0;
        tick();
        tick();
        CLR_STATUS = 1'b1;
        tick();
        CLR_STATUS = 1'b0;
        checks++; if (LOCK_LOST !== 1'b1) begin errors++; $display("FAIL coincide_lost got %0b expected 1", LOCK_LOST); end
        checks++; if (LOSS_COUNT !== 8'd1) begin errors++; $display("FAIL coincide_count got %0d expected 1", LOSS_COUNT); end
        CLR_STATUS = 1'b1;
        tick();
        CLR_STATUS = 1'b0;
        checks++; if (LOSS_COUNT !== 8'd0) begin errors++; $display("FAIL clr_count got %0d expected 0", LOSS_COUNT); end
    endtask

    task automatic test_reset_mid_sequence();
        bit ok;
        do_reset();
        PLL_LOCK = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (STATE == 2'd2) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL rst_wait_pcs got state %0d expected 2", STATE); end
        RESETN = 1'b0;
        tick();
        checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL rst_pcs_state got %0d expected 0", STATE); end
        checks++; if (LANE_PMA_ARST_N !== 1'b0) begin errors++; $display("FAIL rst_pcs_pma got %0b expected 0", LANE_PMA_ARST_N); end
        checks++; if (LANE_PCS_ARST_N !== 1'b0) begin errors++; $display("FAIL rst_pcs_pcs got %0b expected 0", LANE_PCS_ARST_N); end
        checks++; if (READY !== 1'b0) begin errors++; $display("FAIL rst_pcs_ready got %0b expected 0", READY); end
        checks++; if (LOCK_LOST !== 1'b0) begin errors++; $display("FAIL rst_pcs_lost got %0b expected 0", LOCK_LOST); end
        checks++; if (LOSS_COUNT !== 8'd0) begin errors++; $display("FAIL rst_pcs_count got %0d expected 0", LOSS_COUNT); end
        RESETN = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (READY === 1'b1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL rst_wait_ready got %0b expected 1", READY); end
        RESETN   = 1'b0;
        PLL_LOCK = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (LOCK_LOST !== 1'b0) begin errors++; $display("FAIL rst_ready_lost got %0b expected 0 at cycle %0d", LOCK_LOST, k); end
        end
        checks++; if (LOSS_COUNT !== 8'd0) begin errors++; $display("FAIL rst_ready_count got %0d expected 0", LOSS_COUNT); end
        RESETN = 1'b1;
    endtask

    initial begin
        RESETN     = 1'b0;
        PLL_LOCK   = 1'b0;
        CLR_STATUS = 1'b0;
        test_reset();
        test_lock_sequence();
        test_glitch();
        test_loss_in_ready();
        test_timeout();
        test_loss_saturation();
        test_reset_mid_sequence();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_pll_lock_sequencer.md
TX_PLL_LOCK_SEQUENCER -- requirements
Module: tx_pll_lock_sequencer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2: flop stages synchronizing PLL_LOCK; legal values 2-4.
REQ-002 The block SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before lane reset release.
REQ-003 The block SHALL have parameter PMA_RST_CYCLES, default 64: cycles spent in the PMA_RST state.
REQ-004 The block SHALL have parameter PCS_RST_CYCLES, default 32: cycles spent in the PCS_RST state.
REQ-005 The block SHALL have parameter TIMEOUT_CYCLES, default 65536: WAIT_LOCK cycles before LOCK_TIMEOUT is set.
REQ-006 The block SHALL have the port CLK, input, 1 bit: the single clock; a free-running fabric clock, never CLK_125 or BIT_CLK.
REQ-007 The block SHALL have the port RESETN, input, 1 bit: synchronous, active-low reset.
REQ-008 The block SHALL have the port PLL_LOCK, input, 1 bit: asynchronous lock output from the transmit PLL.
REQ-009 The block SHALL have the port CLR_STATUS, input, 1 bit: one-cycle pulse that clears LOCK_TIMEOUT and LOSS_COUNT.
REQ-010 The block SHALL have the port LANE_PMA_ARST_N, output, 1 bit: lane PMA reset, active-low.
REQ-011 The block SHALL have the port LANE_PCS_ARST_N, output, 1 bit: lane PCS reset, active-low.
REQ-012 The block SHALL have the port READY, output, 1 bit: high when the PLL is locked and the lane is out of reset.
REQ-013 The block SHALL have the port LOCK_LOST, output, 1 bit: one-cycle pulse on loss of lock after lock qualification.
REQ-014 The block SHALL have the port LOCK_TIMEOUT, output, 1 bit: sticky flag for a lock timeout.
REQ-015 The block SHALL have the port LOSS_COUNT, output, 8 bits: saturating count of lock-loss events.
REQ-016 The block SHALL have the port STATE, output, 2 bits: current state; WAIT_LOCK=0, PMA_RST=1, PCS_RST=2, READY=3.

Function
REQ-017 All flops SHALL be clocked on the CLK rising edge; lock_s SHALL be the output of the last of SYNC_STAGES synchronizer flops on PLL_LOCK, and no other logic SHALL read PLL_LOCK.
REQ-018 WAIT_LOCK: both ARST_N outputs low, READY low; the stable counter SHALL increment while lock_s=1 and clear to 0 while lock_s=0.
REQ-019 The block SHALL move from WAIT_LOCK to PMA_RST on the edge where lock_s has been 1 for LOCK_STABLE_CYCLES consecutive cycles.
REQ-020 PMA_RST SHALL last exactly PMA_RST_CYCLES cycles, with LANE_PMA_ARST_N=0 and LANE_PCS_ARST_N=0, and then move to PCS_RST.
REQ-021 PCS_RST SHALL last exactly PCS_RST_CYCLES cycles, with LANE_PMA_ARST_N=1 and LANE_PCS_ARST_N=0, and then move to READY.
REQ-022 READY state: both ARST_N outputs 1 and READY=1; all outputs SHALL be registered, with no combinational path from input to output.
REQ-023 lock_s=0 in PMA_RST, PCS_RST or READY SHALL cause, on the next edge: state WAIT_LOCK; both ARST_N outputs 0; READY 0; LOCK_LOST=1 for exactly one cycle; LOSS_COUNT incremented, saturating at 255.
REQ-024 lock_s=0 in WAIT_LOCK SHALL NOT pulse LOCK_LOST or change LOSS_COUNT.
REQ-025 The timeout counter SHALL clear on entry to WAIT_LOCK and count every cycle spent in WAIT_LOCK; at TIMEOUT_CYCLES it SHALL set LOCK_TIMEOUT and hold its count, and the FSM SHALL keep waiting.
REQ-026 LOCK_TIMEOUT SHALL stay set until RESETN or CLR_STATUS, and SHALL NOT be cleared by reaching READY.
REQ-027 CLR_STATUS on the same cycle as a loss event SHALL leave LOSS_COUNT=1, and on the same cycle as a timeout SHALL leave LOCK_TIMEOUT=1; the new event wins.
REQ-028 Counter widths SHALL be $clog2(parameter+1), with no wrap-around in any counter.

Reset
REQ-029 RESETN=0 sampled on an edge SHALL force: synchronizer flops 0, all counters 0, STATE=WAIT_LOCK, LANE_PMA_ARST_N=0, LANE_PCS_ARST_N=0, READY=0, LOCK_LOST=0, LOCK_TIMEOUT=0, LOSS_COUNT=0.
REQ-030 Reset SHALL override all other inputs, including CLR_STATUS and lock changes.
REQ-031 A reset taken in READY SHALL NOT produce a LOCK_LOST pulse or a LOSS_COUNT increment.

Verification (SYNC=2, STABLE=8, PMA=4, PCS=4, TIMEOUT=32)
REQ-032 Bench: PLL_LOCK held 1 from reset release -> READY rises exactly 18 cycles after the first edge sampling PLL_LOCK=1; LANE_PMA_ARST_N rises 4 cycles before LANE_PCS_ARST_N.
REQ-033 Bench: PLL_LOCK glitches low for 1 cycle after 6 stable cycles -> the stable count restarts, and READY is delayed by 7 cycles relative to REQ-032.
REQ-034 Bench: PLL_LOCK drops in READY -> 2 cycles later LOCK_LOST pulses once, READY=0, both ARST_N=0, LOSS_COUNT=1; PLL_LOCK restored -> full sequence reruns.
REQ-035 Bench: PLL_LOCK held 0 -> LOCK_TIMEOUT=1 after 32 WAIT_LOCK cycles; it stays 1 through a later READY and clears on CLR_STATUS.
REQ-036 Bench: 260 loss events -> LOSS_COUNT=255; CLR_STATUS coincident with a loss -> LOSS_COUNT=1.
REQ-037 Bench: RESETN=0 asserted while in PCS_RST -> next cycle all outputs at reset values, LOCK_LOST=0, LOSS_COUNT unchanged at 0.
